bus_cycle_probe: RTL and testbench

//  Passive, parametrised 68000 bus observer for the CPLD devboard; successor to the all-inputs, TP1-tied-low probe.

---
 rtl/bus_cycle_probe_if.sv | 31 +++
 rtl/bus_cycle_probe.sv | 189 ++++++++++++++++++
 tb/tb_bus_cycle_probe.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_cycle_probe_if.sv
// 68000 bus bundle seen by bus_cycle_probe.
// master: the board/CPU side that owns the bus signals.
// slave:  the probe, which only observes them and returns TP1 and the BERR request.
`timescale 1ns/1ps
interface bus_cycle_probe_if #(
    parameter int unsigned ADDR_W = 23,
    parameter int unsigned DATA_W = 16
);
    logic              as;
    logic              uds;
    logic              lds;
    logic              rw;
    logic [2:0]        fc;
    logic              dtack;
    logic              berr;
    logic              vpa;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              tp1;
    logic              berr_oe;

    modport master (
        output as, uds, lds, rw, fc, dtack, berr, vpa, a, d,
        input  tp1, berr_oe
    );

    modport slave (
        input  as, uds, lds, rw, fc, dtack, berr, vpa, a, d,
        output tp1, berr_oe
    );
endinterface

// File: rtl/bus_cycle_probe.sv
// Passive 68000 bus-cycle observer. Synchronises the bus strobes, follows each
// AS-framed cycle and logs {term, RW, FC, wcnt, A, D} into a first-word-fall-through
// FIFO. TP1 pulses for one clock when a cycle starts at the match address.
// Optional feature macro: TIMEOUT_BERR_EN (BERR request on timeout).
// UDS/LDS travel on the interface for the board; the record has no lane field,
// so they are not sampled here.
`timescale 1ns/1ps
module bus_cycle_probe #(
    parameter int unsigned        ADDR_W     = 23,
    parameter int unsigned        DATA_W     = 16,
    parameter int unsigned        DEPTH      = 8,
    parameter int unsigned        TIMEOUT    = 255,
    parameter logic [ADDR_W-1:0]  MATCH_ADDR = '0,
    parameter logic [ADDR_W-1:0]  MATCH_MASK = '1,
    localparam int unsigned       REC_W      = 14 + ADDR_W + DATA_W,
    localparam int unsigned       FILL_W     = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                reset,
    bus_cycle_probe_if.slave    bus,
    input  logic                rd_en,
    output logic                rd_valid,
    output logic [REC_W-1:0]    rd_data,
    output logic [FILL_W-1:0]   fill,
    output logic                overflow
);
    localparam int unsigned PTR_W      = $clog2(DEPTH);
    localparam logic [7:0]  TimeoutCnt = 8'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StWait, StData, StEnd} state_e;

    // Strobe synchronisers, packed {as, dtack, berr, vpa}; reset to negated.
    logic [3:0] sync1_q, sync2_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= {bus.as, bus.dtack, bus.berr, bus.vpa};
            sync2_q <= sync1_q;
        end
    end

    logic as_on, dtack_on, berr_on, vpa_on;
    assign as_on    = !sync2_q[3];
    assign dtack_on = !sync2_q[2];
    assign berr_on  = !sync2_q[1];
    assign vpa_on   = !sync2_q[0];

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        fc_q, fc_d;
    logic              rw_q, rw_d;
    logic [7:0]        wcnt_q, wcnt_d;
    logic [1:0]        term_q, term_d;
    logic              push;
    logic [REC_W-1:0]  push_rec;
    logic              tp1_c, berr_oe_c;

    // Cycle tracker state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            fc_q    <= '0;
            rw_q    <= 1'b0;
            wcnt_q  <= '0;
            term_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            fc_q    <= fc_d;
            rw_q    <= rw_d;
            wcnt_q  <= wcnt_d;
            term_q  <= term_d;
        end
    end

    logic [7:0] wcnt_inc;
    assign wcnt_inc = (wcnt_q == 8'hFF) ? wcnt_q : wcnt_q + 8'd1;

    // Next state, record assembly and strobes.
    // In WAIT: termination beats abort, and abort beats timeout on the same clock.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        fc_d      = fc_q;
        rw_d      = rw_q;
        wcnt_d    = wcnt_q;
        term_d    = term_q;
        push      = 1'b0;
        push_rec  = {term_q, rw_q, fc_q, wcnt_q, addr_q, bus.d};
        tp1_c     = 1'b0;
        berr_oe_c = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (as_on) begin
                    addr_d  = bus.a;
                    fc_d    = bus.fc;
                    rw_d    = bus.rw;
                    wcnt_d  = '0;
                    state_d = StWait;
                    tp1_c   = ((bus.a & MATCH_MASK) == (MATCH_ADDR & MATCH_MASK));
                end
            end
            StWait: begin
                wcnt_d = wcnt_inc;
                if (berr_on) begin
                    term_d  = 2'b01;
                    state_d = StData;
                end else if (dtack_on) begin
                    term_d  = 2'b00;
                    state_d = StData;
                end else if (vpa_on) begin
                    term_d  = 2'b10;
                    state_d = StData;
                end else if (!as_on) begin
                    state_d = StIdle;
                end else if (wcnt_inc == TimeoutCnt) begin
                    term_d   = 2'b11;
                    state_d  = StEnd;
                    push     = 1'b1;
                    push_rec = {2'b11, rw_q, fc_q, wcnt_inc, addr_q, {DATA_W{1'b0}}};
`ifdef TIMEOUT_BERR_EN
                    berr_oe_c = 1'b1;
`endif
                end
            end
            StData: begin
                // D is stable: the termination has already crossed both sync flops.
                push    = 1'b1;
                state_d = StEnd;
            end
            StEnd: begin
                if (!as_on) begin
                    state_d = StIdle;
                end
`ifdef TIMEOUT_BERR_EN
                berr_oe_c = (term_q == 2'b11) && as_on;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.tp1     = tp1_c && !reset;
    assign bus.berr_oe = berr_oe_c && !reset;

    logic [REC_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]  wptr_q, rptr_q;
    logic [FILL_W-1:0] fill_q;
    logic              overflow_q;
    logic              full, pop, push_ok;

    assign full    = (fill_q == FILL_W'(DEPTH));
    assign pop     = rd_en && (fill_q != '0);
    assign push_ok = push && (!full || pop);

    // Capture FIFO; a push into a full FIFO is dropped unless a pop frees a slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            fill_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wptr_q] <= push_rec;
                wptr_q      <= wptr_q + PTR_W'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            unique case ({push_ok, pop})
                2'b10:   fill_q <= fill_q + FILL_W'(1);
                2'b01:   fill_q <= fill_q - FILL_W'(1);
                default: fill_q <= fill_q;
            endcase
            if (push && full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign rd_valid = (fill_q != '0);
    assign rd_data  = mem[rptr_q];
    assign fill     = fill_q;
    assign overflow = overflow_q;
endmodule

// File: tb/tb_bus_cycle_probe.sv
// Self-checking bench for bus_cycle_probe: directed table, random cycles against a
// record-queue model, and hand sequences for overflow, push+pop when full and reset.
`timescale 1ns/1ps
module tb_bus_cycle_probe;
    localparam int unsigned AW      = 23;
    localparam int unsigned DW      = 16;
    localparam int unsigned DEPTH   = 8;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned RECW    = 14 + AW + DW;
    localparam logic [AW-1:0] MATCH = 23'h000200;

    localparam int K_DT  = 0;  // DTACK
    localparam int K_BE  = 1;  // BERR
    localparam int K_VP  = 2;  // VPA
    localparam int K_TMO = 3;  // no termination
    localparam int K_ABT = 4;  // AS dropped early
    localparam int K_ALL = 5;  // BERR+DTACK+VPA together
    localparam int K_DV  = 6;  // DTACK+VPA together

    typedef logic [RECW-1:0] rec_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            rd_en;
    logic            rd_valid;
    rec_t            rd_data;
    logic [3:0]      fill;
    logic            overflow;

    bus_cycle_probe_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    bus_cycle_probe #(
        .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT),
        .MATCH_ADDR(MATCH), .MATCH_MASK({AW{1'b1}})
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .rd_en(rd_en), .rd_valid(rd_valid),
        .rd_data(rd_data), .fill(fill), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    rec_t model_q[$];
    bit   ovf_exp = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.as = 1'b1; bus.uds = 1'b1; bus.lds = 1'b1;
        bus.dtack = 1'b1; bus.berr = 1'b1; bus.vpa = 1'b1;
    endtask

    function automatic logic [1:0] term_of(input int kind);
        case (kind)
            K_BE, K_ALL: return 2'b01;
            K_VP:        return 2'b10;
            K_TMO:       return 2'b11;
            default:     return 2'b00;
        endcase
    endfunction

    // Wait count equals clocks from AS assertion to termination assertion (both see
    // the same sync delay); a timeout record carries TIMEOUT and a zero data field.
    function automatic rec_t exp_rec(input logic [AW-1:0] addr, input logic [2:0] f,
                                     input logic r, input logic [DW-1:0] dat,
                                     input int kind, input int k);
        if (kind == K_TMO) return {2'b11, r, f, 8'(TIMEOUT), addr, {DW{1'b0}}};
        return {term_of(kind), r, f, 8'(k), addr, dat};
    endfunction

    // One AS-framed cycle: termination asserted k clocks after AS, AS held 'hold'
    // clocks for timeout/abort kinds. Then the per-cycle outputs are checked.
    task automatic run_cycle(input string name, input logic [AW-1:0] addr,
                             input logic [2:0] f, input logic r, input logic [DW-1:0] dat,
                             input int kind, input int k, input int hold_in,
                             input bit pop_at_push, input int exp_tp1);
        int hold;
        int tp1_cnt;
        int oe_cnt;
        int oe_exp;
        tp1_cnt = 0;
        oe_cnt  = 0;
        hold = (kind == K_TMO || kind == K_ABT) ? hold_in : k + 4;
        bus.a = addr; bus.fc = f; bus.rw = r; bus.d = dat;
        bus.uds = 1'b0; bus.lds = 1'b0; bus.as = 1'b0;
        for (int i = 0; i < hold + 4; i++) begin
            tick();
            if (bus.tp1) tp1_cnt++;
            if (bus.berr_oe) oe_cnt++;
            if (pop_at_push && i == k + 2) begin
                check({name, "_pophead"}, rd_data, model_q[0]);
                void'(model_q.pop_front());
                rd_en = 1'b1;
            end
            if (pop_at_push && i == k + 3) rd_en = 1'b0;
            if (i == k - 1) begin
                case (kind)
                    K_DT:  bus.dtack = 1'b0;
                    K_BE:  bus.berr = 1'b0;
                    K_VP:  bus.vpa = 1'b0;
                    K_ALL: begin bus.dtack = 1'b0; bus.berr = 1'b0; bus.vpa = 1'b0; end
                    K_DV:  begin bus.dtack = 1'b0; bus.vpa = 1'b0; end
                    default: ;
                endcase
            end
            if (i == hold - 1) bus_idle();
        end
        if (kind != K_ABT) begin
            if (model_q.size() < DEPTH) model_q.push_back(exp_rec(addr, f, r, dat, kind, k));
            else ovf_exp = 1'b1;
        end
`ifdef TIMEOUT_BERR_EN
        oe_exp = (kind == K_TMO) ? hold - int'(TIMEOUT) : 0;
`else
        oe_exp = 0;
`endif
        check({name, "_tp1"}, 64'(tp1_cnt), 64'(exp_tp1));
        check({name, "_berr_oe"}, 64'(oe_cnt), 64'(oe_exp));
        check({name, "_fill"}, 64'(fill), 64'(model_q.size()));
        check({name, "_overflow"}, 64'(overflow), 64'(ovf_exp));
    endtask

    task automatic drain(input string name);
        while (model_q.size() > 0) begin
            check({name, "_rd_valid"}, 64'(rd_valid), 64'd1);
            check({name, "_rd_data"}, rd_data, model_q.pop_front());
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
        end
        check({name, "_empty"}, 64'(rd_valid), 64'd0);
        check({name, "_fill0"}, 64'(fill), 64'd0);
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        logic [2:0]    fc;
        logic          rw;
        logic [DW-1:0] data;
        int            kind;
        int            k;
        int            exp_tp1;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [AW-1:0] ra;
        int            rk;
        int            kind;
        int            hold;
        int            tp1_cnt;

        vecs[0] = '{23'h000200, 3'd5, 1'b1, 16'hBEEF, K_DT,  3, 1};
        vecs[1] = '{23'h000201, 3'd5, 1'b1, 16'h1234, K_DT,  3, 0};
        vecs[2] = '{23'h03AAAA, 3'd1, 1'b0, 16'h5A5A, K_BE,  2, 0};
        vecs[3] = '{23'h000200, 3'd6, 1'b1, 16'h0F0F, K_VP,  5, 1};
        vecs[4] = '{23'h7FFFFF, 3'd2, 1'b0, 16'hFFFF, K_DT,  1, 0};
        vecs[5] = '{23'h000200, 3'd5, 1'b1, 16'hAAAA, K_ABT, 4, 1};
        vecs[6] = '{23'h000100, 3'd2, 1'b0, 16'h7777, K_ALL, 6, 0};

        bus_idle();
        bus.a = '0; bus.d = '0; bus.fc = '0; bus.rw = 1'b1;
        rd_en = 1'b0;
        reset = 1'b1;
        tick(); tick();
        check("rst_tp1", 64'(bus.tp1), 64'd0);
        check("rst_rd_valid", 64'(rd_valid), 64'd0);
        check("rst_fill", 64'(fill), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_berr_oe", 64'(bus.berr_oe), 64'd0);
        reset = 1'b0;
        tick(); tick();

        // Directed table, each record read back right away.
        for (int i = 0; i < 7; i++) begin
            run_cycle($sformatf("vec%0d", i), vecs[i].addr, vecs[i].fc, vecs[i].rw,
                      vecs[i].data, vecs[i].kind, vecs[i].k, vecs[i].k, 1'b0, vecs[i].exp_tp1);
            drain($sformatf("vec%0d", i));
        end
        run_cycle("dtack_vpa", 23'h000010, 3'd1, 1'b1, 16'h4321, K_DV, 2, 0, 1'b0, 0);
        drain("dtack_vpa");

        // Timeout: AS held 40 clocks with nothing terminating it.
        run_cycle("timeout", 23'h001234, 3'd5, 1'b1, 16'hDEAD, K_TMO, 1, 40, 1'b0, 0);
        drain("timeout");

        // Random cycles against the queue model.
        for (int n = 0; n < 30; n++) begin
            ra   = ($urandom_range(0, 3) == 0) ? MATCH : AW'($urandom);
            kind = $urandom_range(0, 6);
            rk   = $urandom_range(1, 10);
            hold = (kind == K_TMO) ? int'(TIMEOUT) + $urandom_range(1, 6) : rk;
            run_cycle($sformatf("rnd%0d", n), ra, 3'($urandom), 1'($urandom), 16'($urandom),
                      kind, rk, hold, 1'b0, (ra == MATCH) ? 1 : 0);
            if (model_q.size() == DEPTH || $urandom_range(0, 3) == 0) drain($sformatf("rnd%0d", n));
        end
        drain("rnd_end");

        // Nine cycles with no reads: ninth is dropped and overflow sticks.
        for (int n = 0; n < 9; n++) begin
            run_cycle($sformatf("ovf%0d", n), AW'(23'h000400 + n), 3'd1, 1'b0, 16'(16'h1000 + n),
                      K_DT, 1 + (n % 3), 0, 1'b0, 0);
        end
        check("ovf_fill8", 64'(fill), 64'd8);
        check("ovf_flag", 64'(overflow), 64'd1);
        drain("ovf");
        check("ovf_sticky", 64'(overflow), 64'd1);

        // Reset mid-WAIT with AS still low: the open cycle is recaptured afresh.
        run_cycle("pre_rst", 23'h000055, 3'd2, 1'b1, 16'h5555, K_DT, 2, 0, 1'b0, 0);
        bus.a = MATCH; bus.fc = 3'd6; bus.rw = 1'b0; bus.d = 16'hC0DE;
        bus.uds = 1'b0; bus.lds = 1'b0; bus.as = 1'b0;
        tp1_cnt = 0;
        for (int i = 0; i < 18; i++) begin
            tick();
            if (bus.tp1) tp1_cnt++;
            if (i == 5) reset = 1'b1;
            if (i == 6) begin
                check("midrst_fill", 64'(fill), 64'd0);
                check("midrst_rd_valid", 64'(rd_valid), 64'd0);
                check("midrst_tp1", 64'(bus.tp1), 64'd0);
                check("midrst_overflow", 64'(overflow), 64'd0);
                reset = 1'b0;
                model_q.delete();
                ovf_exp = 1'b0;
            end
            if (i == 9) bus.dtack = 1'b0;
            if (i == 13) bus_idle();
        end
        check("midrst_tp1_pulses", 64'(tp1_cnt), 64'd2);
        check("midrst_fill1", 64'(fill), 64'd1);
        model_q.push_back(exp_rec(MATCH, 3'd6, 1'b0, 16'hC0DE, K_DT, 3));
        drain("midrst");

        // Full FIFO, pop on the same clock as the ninth push.
        for (int n = 0; n < 8; n++) begin
            run_cycle($sformatf("full%0d", n), AW'(23'h000600 + n), 3'd2, 1'b1, 16'(16'h2000 + n),
                      K_DT, 2, 0, 1'b0, 0);
        end
        run_cycle("full_pp", 23'h000700, 3'd5, 1'b0, 16'h9999, K_VP, 3, 0, 1'b1, 0);
        check("pp_fill8", 64'(fill), 64'd8);
        check("pp_overflow0", 64'(overflow), 64'd0);
        drain("pp");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Whole-run guard so the bench never hangs.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
